// File: rtl/piso_serializer.sv
// Parallel-in / serial-out transmitter.
// A WIDTH-bit word is accepted on a valid/ready port and sent one bit per clock
// on ser_out, with its complement on ser_out_n. The next word can be loaded on
// the last bit cycle of the current frame, so frames can run back to back with
// no idle gap. All outputs come from registered state only.
module piso_serializer #(
    parameter int WIDTH     = 8,   // bits per frame, must be >= 2
    parameter int MSB_FIRST = 1    // 1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_out_n,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end
);

    // Bit counter width; WIDTH >= 2 keeps this at least 1.
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // FSM encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             in_shift;
    logic             last_bit;
    logic             accept;
    logic             out_bit;
    logic [WIDTH-1:0] shreg_shifted;

    // ------------------------------------------------------------------
    // Shift-register datapath: move every bit one place toward the output
    // end and fill the vacated far end with 0.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (MSB_FIRST != 0) begin : g_msb
                // Output end is bit WIDTH-1, so data moves upward.
                if (gi == 0) begin : g_fill
                    assign shreg_shifted[gi] = 1'b0;
                end else begin : g_move
                    assign shreg_shifted[gi] = shreg_q[gi-1];
                end
            end else begin : g_lsb
                // Output end is bit 0, so data moves downward.
                if (gi == WIDTH - 1) begin : g_fill
                    assign shreg_shifted[gi] = 1'b0;
                end else begin : g_move
                    assign shreg_shifted[gi] = shreg_q[gi+1];
                end
            end
        end

        if (MSB_FIRST != 0) begin : g_out_msb
            assign out_bit = shreg_q[WIDTH-1];
        end else begin : g_out_lsb
            assign out_bit = shreg_q[0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake and status decode, all from registered state.
    // ------------------------------------------------------------------
    assign in_shift = (state_q == ST_SHIFT);
    assign last_bit = in_shift && (cnt_q == CNT_LAST);

    // Ready when idle, or on the final bit so the next frame follows with no gap.
    assign load_ready = (state_q == ST_IDLE) || last_bit;
    assign accept     = load_valid && load_ready;

    assign ser_valid   = in_shift;
    // Gate with ser_valid so the line is a clean 0 outside a frame.
    assign ser_out     = in_shift && out_bit;
    assign ser_out_n   = ~ser_out;
    assign frame_start = in_shift && (cnt_q == CNT_ZERO);
    assign frame_end   = last_bit;

    // Next-state logic: load on accept, shift mid-frame, clear when the frame ends unrefilled.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;

        if (accept) begin
            // load_data is only looked at here, so X on it while idle is harmless.
            state_d = ST_SHIFT;
            shreg_d = load_data;
            cnt_d   = CNT_ZERO;
        end else if (in_shift) begin
            if (cnt_q != CNT_LAST) begin
                shreg_d = shreg_shifted;
                cnt_d   = cnt_q + CNT_ONE;
            end else begin
                // Frame finished with nothing queued behind it.
                state_d = ST_IDLE;
                shreg_d = '0;
                cnt_d   = CNT_ZERO;
            end
        end
    end

    // State registers; reset acts immediately and discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

`ifndef SYNTHESIS
    // Internal consistency checks for simulation.
    ap_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q <= CNT_LAST);

    ap_idle_clean: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_IDLE) |-> ((shreg_q == '0) && (cnt_q == CNT_ZERO)));

    ap_flags_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(frame_start && frame_end));

    ap_complement: assert property (@(posedge clk) disable iff (!rst_n)
        ser_out_n == ~ser_out);
`endif

endmodule
